// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU ops straight to the MEM/WB register,
// runs loads/stores through a variable-latency request/ack handshake with timeout abort.
module mem_stage #(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int PCW     = 8,
  parameter int RW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic [DW-1:0]  ex_alu,
  input  logic [DW-1:0]  ex_sdata,
  input  logic [PCW-1:0] ex_pc1,
  input  logic [2:0]     ex_vsel,
  input  logic [RW-1:0]  ex_rd,
  input  logic           ex_wreg,
  input  logic           ex_load,
  input  logic           ex_store,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  output logic           mem_err,
  output logic           wb_valid,
  output logic [DW-1:0]  wb_alu,
  output logic [DW-1:0]  wb_mdata,
  output logic [PCW-1:0] wb_pc1,
  output logic [2:0]     wb_vsel,
  output logic [RW-1:0]  wb_rd,
  output logic           wb_wreg
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_next;
  logic [7:0]     wait_cnt;
  logic           transfer, is_mem_op, complete, abort;

  logic [DW-1:0]  cap_alu;
  logic [PCW-1:0] cap_pc1;
  logic [2:0]     cap_vsel;
  logic [RW-1:0]  cap_rd;
  logic           cap_wreg;
  logic           cap_load;

  assign ex_ready  = (state == IDLE);
  assign transfer  = ex_valid && ex_ready;
  assign is_mem_op = ex_load || ex_store;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Ack takes priority over the timeout when both land on the same edge.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (transfer && is_mem_op) state_next = ACCESS;
      end
      ACCESS: begin
        if (mem_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_alu    <= '0;
      wb_mdata  <= '0;
      wb_pc1    <= '0;
      wb_vsel   <= '0;
      wb_rd     <= '0;
      wb_wreg   <= 1'b0;
      cap_alu   <= '0;
      cap_pc1   <= '0;
      cap_vsel  <= '0;
      cap_rd    <= '0;
      cap_wreg  <= 1'b0;
      cap_load  <= 1'b0;
    end else begin
      mem_err  <= 1'b0;
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        wait_cnt <= '0;
        if (transfer && is_mem_op) begin
          cap_alu   <= ex_alu;
          cap_pc1   <= ex_pc1;
          cap_vsel  <= ex_vsel;
          cap_rd    <= ex_rd;
          cap_wreg  <= ex_wreg;
          cap_load  <= ex_load && !ex_store;
          mem_req   <= 1'b1;
          mem_we    <= ex_store;
          mem_addr  <= ex_alu[AW-1:0];
          mem_wdata <= ex_sdata;
        end else if (transfer) begin
          wb_valid <= 1'b1;
          wb_alu   <= ex_alu;
          wb_mdata <= '0;
          wb_pc1   <= ex_pc1;
          wb_vsel  <= ex_vsel;
          wb_rd    <= ex_rd;
          wb_wreg  <= ex_wreg;
        end
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
        if (complete || abort) begin
          mem_req  <= 1'b0;
          mem_err  <= abort;
          wb_valid <= 1'b1;
          wb_alu   <= cap_alu;
          wb_pc1   <= cap_pc1;
          wb_vsel  <= cap_vsel;
          wb_rd    <= cap_rd;
          // A timed-out op is squashed so write-back never commits it.
          wb_wreg  <= complete ? cap_wreg : 1'b0;
          wb_mdata <= (complete && cap_load) ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random op mix,
// checked per transaction against expectations derived from the stage's rules.
module tb_mem_stage;

  localparam int DW = 16, AW = 8, PCW = 8, RW = 3, TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic           ex_valid, ex_ready;
  logic [DW-1:0]  ex_alu, ex_sdata;
  logic [PCW-1:0] ex_pc1;
  logic [2:0]     ex_vsel;
  logic [RW-1:0]  ex_rd;
  logic           ex_wreg, ex_load, ex_store;
  logic           mem_req, mem_we, mem_err, mem_ack;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic           wb_valid, wb_wreg;
  logic [DW-1:0]  wb_alu, wb_mdata;
  logic [PCW-1:0] wb_pc1;
  logic [2:0]     wb_vsel;
  logic [RW-1:0]  wb_rd;

  int errCount = 0;
  int checkCount = 0;
  logic [DW-1:0] lastAlu;

  mem_stage #(.DW(DW), .AW(AW), .PCW(PCW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .ex_pc1(ex_pc1), .ex_vsel(ex_vsel),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_load(ex_load), .ex_store(ex_store),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .wb_valid(wb_valid), .wb_alu(wb_alu), .wb_mdata(wb_mdata), .wb_pc1(wb_pc1),
    .wb_vsel(wb_vsel), .wb_rd(wb_rd), .wb_wreg(wb_wreg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    ex_valid  = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    step();
    mem_ack = 1'b0;
    checkOutput("idle_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("idle_wb_alu_hold", 32'(wb_alu), 32'(lastAlu));
    checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
    checkOutput("idle_mem_err", 32'(mem_err), 32'd0);
    checkOutput("idle_ex_ready", 32'(ex_ready), 32'd1);
  endtask

  task automatic applyStimulus_alu(input logic [DW-1:0] alu);
    logic [PCW-1:0] pc1;
    logic [2:0] vsel;
    logic [RW-1:0] rd;
    logic wreg;
    pc1 = 8'($urandom); vsel = 3'($urandom); rd = 3'($urandom); wreg = 1'($urandom);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
    ex_alu = alu; ex_sdata = 16'($urandom); ex_pc1 = pc1; ex_vsel = vsel; ex_rd = rd; ex_wreg = wreg;
    checkOutput("alu_ex_ready", 32'(ex_ready), 32'd1);
    step();
    ex_valid = 1'b0;
    lastAlu = alu;
    checkOutput("alu_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("alu_wb_alu", 32'(wb_alu), 32'(alu));
    checkOutput("alu_wb_mdata", 32'(wb_mdata), 32'd0);
    checkOutput("alu_wb_pc1", 32'(wb_pc1), 32'(pc1));
    checkOutput("alu_wb_vsel", 32'(wb_vsel), 32'(vsel));
    checkOutput("alu_wb_rd", 32'(wb_rd), 32'(rd));
    checkOutput("alu_wb_wreg", 32'(wb_wreg), 32'(wreg));
    checkOutput("alu_mem_req", 32'(mem_req), 32'd0);
  endtask

  // ackAt = request cycle in which ack is driven (1 = first); 0 or >TIMEOUT = never.
  task automatic applyStimulus_mem(input logic isLoad, input logic isStore,
                                   input logic [DW-1:0] alu, input logic [DW-1:0] sdata,
                                   input logic [DW-1:0] rdata, input int ackAt);
    logic [PCW-1:0] pc1;
    logic [2:0] vsel;
    logic [RW-1:0] rd;
    logic wreg;
    bit done;
    pc1 = 8'($urandom); vsel = 3'($urandom); rd = 3'($urandom); wreg = 1'($urandom);
    ex_valid = 1'b1; ex_load = isLoad; ex_store = isStore;
    ex_alu = alu; ex_sdata = sdata; ex_pc1 = pc1; ex_vsel = vsel; ex_rd = rd; ex_wreg = wreg;
    checkOutput("mem_ex_ready_accept", 32'(ex_ready), 32'd1);
    step();
    done = 0;
    for (int c = 1; c <= TIMEOUT && !done; c++) begin
      // Upstream keeps offering a different op; it must not be taken.
      ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
      ex_alu = 16'($urandom); ex_sdata = 16'($urandom); ex_wreg = 1'b1;
      checkOutput("acc_mem_req", 32'(mem_req), 32'd1);
      checkOutput("acc_mem_addr", 32'(mem_addr), 32'(alu[AW-1:0]));
      checkOutput("acc_mem_we", 32'(mem_we), 32'(isStore));
      checkOutput("acc_mem_wdata", 32'(mem_wdata), 32'(sdata));
      checkOutput("acc_ex_ready", 32'(ex_ready), 32'd0);
      checkOutput("acc_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("acc_mem_err", 32'(mem_err), 32'd0);
      mem_ack   = (c == ackAt);
      mem_rdata = (c == ackAt) ? rdata : 16'($urandom);
      step();
      mem_ack  = 1'b0;
      ex_valid = 1'b0;
      if (c == ackAt) begin
        done = 1;
        checkOutput("done_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("done_wb_alu", 32'(wb_alu), 32'(alu));
        checkOutput("done_wb_mdata", 32'(wb_mdata), (isLoad && !isStore) ? 32'(rdata) : 32'd0);
        checkOutput("done_wb_pc1", 32'(wb_pc1), 32'(pc1));
        checkOutput("done_wb_vsel", 32'(wb_vsel), 32'(vsel));
        checkOutput("done_wb_rd", 32'(wb_rd), 32'(rd));
        checkOutput("done_wb_wreg", 32'(wb_wreg), 32'(wreg));
        checkOutput("done_mem_req", 32'(mem_req), 32'd0);
        checkOutput("done_mem_err", 32'(mem_err), 32'd0);
        checkOutput("done_ex_ready", 32'(ex_ready), 32'd1);
      end else if (c == TIMEOUT) begin
        done = 1;
        checkOutput("tmo_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("tmo_wb_wreg", 32'(wb_wreg), 32'd0);
        checkOutput("tmo_wb_mdata", 32'(wb_mdata), 32'd0);
        checkOutput("tmo_wb_alu", 32'(wb_alu), 32'(alu));
        checkOutput("tmo_mem_req", 32'(mem_req), 32'd0);
        checkOutput("tmo_mem_err", 32'(mem_err), 32'd1);
        checkOutput("tmo_ex_ready", 32'(ex_ready), 32'd1);
      end
    end
    lastAlu = alu;
    idleCycle();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, "_wb_wreg"}, 32'(wb_wreg), 32'd0);
    checkOutput({tag, "_wb_alu"}, 32'(wb_alu), 32'd0);
    checkOutput({tag, "_wb_mdata"}, 32'(wb_mdata), 32'd0);
    checkOutput({tag, "_wb_pc1"}, 32'(wb_pc1), 32'd0);
    checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    checkOutput({tag, "_wb_vsel"}, 32'(wb_vsel), 32'd0);
    checkOutput({tag, "_ex_ready"}, 32'(ex_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_alu = '0; ex_sdata = '0; ex_pc1 = '0; ex_vsel = '0;
    ex_rd = '0; ex_wreg = 1'b0; ex_load = 1'b0; ex_store = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    lastAlu = '0;
    step();
    step();
    checkResetValues("rst");
    reset = 1'b0;
    idleCycle();

    applyStimulus_alu(16'h0011);
    applyStimulus_alu(16'h0022);
    applyStimulus_alu(16'h0033);
    idleCycle();

    applyStimulus_mem(1'b1, 1'b0, 16'h0042, 16'h0000, 16'hBEEF, 1);
    applyStimulus_mem(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h5555, 4);
    applyStimulus_mem(1'b1, 1'b0, 16'h0077, 16'h0000, 16'hAAAA, 0);
    applyStimulus_alu(16'h0099);
    applyStimulus_mem(1'b1, 1'b0, 16'h0155, 16'h0000, 16'hC0DE, TIMEOUT);
    applyStimulus_mem(1'b1, 1'b1, 16'h0020, 16'h4321, 16'h7777, 2);

    // Reset during the second ACCESS cycle discards the op.
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_alu = 16'h0064; ex_wreg = 1'b1;
    step();
    ex_valid = 1'b0;
    checkOutput("rma_mem_req1", 32'(mem_req), 32'd1);
    step();
    checkOutput("rma_mem_req2", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    lastAlu = '0;
    checkResetValues("rma");
    idleCycle();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    checkOutput("rma_spurious_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rma_spurious_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rma_spurious_wb_mdata", 32'(wb_mdata), 32'd0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0)
        applyStimulus_alu(16'($urandom));
      else
        applyStimulus_mem(kind != 2, kind >= 2, 16'($urandom), 16'($urandom), 16'($urandom),
                          int'($urandom_range(0, TIMEOUT + 2)));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined core, directly upstream of the write-back mux. Accepts one instruction per cycle from the execute stage and performs any load or store through a variable-latency data-memory handshake. Stalls execute while an access is outstanding. Registers the MEM/WB pipeline fields (`alu`, `mdata`, `pc1_wb`, `vsel`, destination) that write-back consumes.

## Interface
- `DW`, 16: data / ALU word width
- `AW`, 8: memory address width; the address is `ex_alu[AW-1:0]`
- `PCW`, 8: PC+1 width
- `RW`, 3: register index width
- `TIMEOUT`, 15: maximum cycles in ACCESS without `mem_ack` before abort (legal range 1..255)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `ex_valid`  in  1  execute stage presents an instruction
- `ex_ready`  out  1  stage can accept; combinational, equals (state==IDLE)
- `ex_alu`  in  DW  ALU result; also the memory address
- `ex_sdata`  in  DW  store data
- `ex_pc1`  in  PCW  PC+1
- `ex_vsel`  in  3  one-hot write-back select (001 alu, 010 mem, 100 pc)
- `ex_rd`  in  RW  destination register
- `ex_wreg`  in  1  register write enable
- `ex_load`  in  1  instruction is a load
- `ex_store`  in  1  instruction is a store
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = write, registered
- `mem_addr`  out  AW  registered address
- `mem_wdata`  out  DW  registered store data
- `mem_rdata`  in  DW  read data, valid in the `mem_ack` cycle
- `mem_ack`  in  1  access complete, single-cycle pulse
- `mem_err`  out  1  one-cycle pulse on timeout abort
- `wb_valid`, `wb_alu` (DW), `wb_mdata` (DW), `wb_pc1` (PCW), `wb_vsel` (3), `wb_rd` (RW), `wb_wreg` (1)  out  MEM/WB register to write-back

## Operation
- States: IDLE and ACCESS. A transfer occurs when `ex_valid && ex_ready`.
- **IDLE, transfer of a non-memory op** (`ex_load==0`, `ex_store==0`):
  - Next edge: `wb_valid=1`; all `wb_*` fields take the `ex_*` values; `wb_mdata=0`.
  - Stays in IDLE.
- **IDLE, transfer of a load or store:**
  - Capture the `ex_*` fields internally.
  - Next edge: `mem_req=1`, `mem_addr=ex_alu[AW-1:0]`, `mem_we=ex_store`, `mem_wdata=ex_sdata`.
  - State becomes ACCESS; `wb_valid=0`.
  - If `ex_load` and `ex_store` are both 1, the op is treated as a store (`mem_we=1`).
- **IDLE, no transfer:** next edge `wb_valid=0`; other `wb_*` fields hold.
- **ACCESS:**
  - `ex_ready=0` and `wb_valid=0` every cycle. The cycle counter `wait_cnt` increments from 0.
  - On an edge where `mem_ack=1`:
    - `mem_req=0`, state IDLE.
    - `wb_valid=1` with the captured fields.
    - `wb_mdata = mem_rdata` for a load, 0 for a store.
  - On an edge where `mem_ack=0` and `wait_cnt==TIMEOUT-1`:
    - `mem_req=0`, state IDLE, `mem_err=1` for one cycle.
    - `wb_valid=1` with `wb_wreg=0` (squashed), `wb_mdata=0`.
  - If `mem_ack` and timeout coincide, ack wins and `mem_err` stays 0.
- `mem_ack` while in IDLE is ignored.
- `wb_vsel` is passed through unchecked; write-back decodes it.

## Timing
- Reset: state IDLE and `wait_cnt=0`. `mem_req`, `mem_we`, `mem_err`, `wb_valid`, `wb_wreg` = 0; `mem_addr`, `mem_wdata`, and all `wb_*` data fields = 0.
- Reset mid-ACCESS: `mem_req` drops at that edge; the in-flight op is discarded with no `wb_valid` and no `mem_err`.
- Non-memory op latency: 1 cycle; back-to-back throughput 1 per cycle.
- Memory op accepted at edge N:
  - `mem_req` is high from N+1.
  - If ack is first seen in cycle N+k (k≥1), `wb_valid` is high after edge N+k and `ex_ready` returns high in the same cycle.
  - Minimum load-to-WB latency: 2 cycles.
  - No new op is accepted until `ex_ready` is high again.
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` stay stable throughout ACCESS.

## Test plan
- Reset, then three back-to-back ALU ops (`ex_alu`=0x0011, 0x0022, 0x0033; `vsel=001`) -> `wb_valid` high for three consecutive cycles with matching `wb_alu`; `mem_req` stays 0.
- Load at `ex_alu=0x0042`, ack in the first request cycle with `mem_rdata=0xBEEF` -> `mem_addr=0x42`, `mem_we=0`; `wb_mdata=0xBEEF` and `wb_valid` at N+2; `ex_ready` low for exactly one cycle.
- Store of `ex_sdata=0x1234` at address 0x10, ack after 4 cycles -> `mem_we=1`, `mem_wdata=0x1234` stable for 4 cycles; `wb_valid` once with `wb_mdata=0`; `ex_valid` held high upstream is not accepted until then.
- No ack with `TIMEOUT=15` -> `mem_req` high for exactly 15 cycles; `mem_err` pulses once; `wb_valid=1` with `wb_wreg=0`; the next op is accepted.
- Ack arrives in the timeout cycle -> normal completion with `mem_err=0`.
- Reset asserted in the 2nd ACCESS cycle -> `mem_req=0` after that edge, no `wb_valid`, all outputs at reset values; a spurious `mem_ack` afterwards is ignored.
